// File: rtl/ssd_scan_scheduler_if.sv
// Display-image load handshake and scan outputs of ssd_scan_scheduler.
// The master is the game logic; the slave is the scan scheduler.
interface ssd_scan_scheduler_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load_valid;
  logic                    load_ready;
  logic [NUM_DIGITS-1:0]   an;
  logic [7:0]              cathodes;
  logic                    frame_done;

  modport master (
    output value, dp_mask, digit_en, load_valid,
    input  load_ready, an, cathodes, frame_done
  );

  modport slave (
    input  value, dp_mask, digit_en, load_valid,
    output load_ready, an, cathodes, frame_done
  );
endinterface

// File: rtl/ssd_scan_scheduler.sv
// Tear-free, double-buffered seven-segment scan scheduler with per-slot anode blanking.
// Optional leading-zero suppression is enabled by defining SSD_LZ_SUPPRESS_EN.
module ssd_scan_scheduler #(
  parameter int NUM_DIGITS   = 8,
  parameter int TICK_DIV     = 262144,
  parameter int BLANK_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  ssd_scan_scheduler_if.slave   bus
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  typedef enum logic {PH_BLANK = 1'b0, PH_SHOW = 1'b1} phase_t;
  localparam phase_t PH_RESET = (BLANK_CYCLES == 0) ? PH_SHOW : PH_BLANK;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'b0000001;
      4'h1: hex_decode = 7'b1001111;
      4'h2: hex_decode = 7'b0010010;
      4'h3: hex_decode = 7'b0000110;
      4'h4: hex_decode = 7'b1001100;
      4'h5: hex_decode = 7'b0100100;
      4'h6: hex_decode = 7'b0100000;
      4'h7: hex_decode = 7'b0001111;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0000100;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b1100000;
      4'hC: hex_decode = 7'b0110001;
      4'hD: hex_decode = 7'b1000010;
      4'hE: hex_decode = 7'b0110000;
      4'hF: hex_decode = 7'b0111000;
      default: hex_decode = 7'b1111111;
    endcase
  endfunction

  logic [CW-1:0]           r_slot_cnt;
  logic [IW-1:0]           r_digit_idx;
  phase_t                  r_phase;
  phase_t                  w_phase_nxt;
  logic [4*NUM_DIGITS-1:0] r_act_value;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_en;
  logic [4*NUM_DIGITS-1:0] r_pend_value;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_pend_en;
  logic                    r_load_ready;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [7:0]              r_cath;
  logic                    r_frame_done;

  logic                    w_slot_end;
  logic                    w_boundary;
  logic                    w_accept;
  logic [CW-1:0]           w_slot_nxt;
  logic [IW-1:0]           w_idx_nxt;
  logic [NUM_DIGITS-1:0]   w_en_eff;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic [7:0]              w_cath_nxt;
`ifdef SSD_LZ_SUPPRESS_EN
  logic                    w_lz_run;
`endif

  assign w_slot_end = (r_slot_cnt == CW'(TICK_DIV - 1));
  assign w_boundary = w_slot_end && (r_digit_idx == IW'(NUM_DIGITS - 1));
  assign w_accept   = bus.load_valid && r_load_ready;

  // Slot counter and digit index successors.
  always_comb begin
    w_slot_nxt = r_slot_cnt + CW'(1);
    w_idx_nxt  = r_digit_idx;
    if (w_slot_end) begin
      w_slot_nxt = {CW{1'b0}};
      if (r_digit_idx == IW'(NUM_DIGITS - 1)) begin
        w_idx_nxt = {IW{1'b0}};
      end else begin
        w_idx_nxt = r_digit_idx + IW'(1);
      end
    end else begin
      w_slot_nxt = r_slot_cnt + CW'(1);
      w_idx_nxt  = r_digit_idx;
    end
  end

  // Effective digit enables; suppression walks down from the most significant digit.
  always_comb begin
    w_en_eff = r_act_en;
`ifdef SSD_LZ_SUPPRESS_EN
    w_lz_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (w_lz_run && (r_act_value[4*i +: 4] == 4'h0)) begin
        w_en_eff[i] = 1'b0;
      end else begin
        w_en_eff[i] = r_act_en[i];
      end
      if (r_act_en[i] && (r_act_value[4*i +: 4] != 4'h0)) begin
        w_lz_run = 1'b0;
      end else begin
        w_lz_run = w_lz_run;
      end
    end
`endif
  end

  // Phase FSM next state and the anode/cathode image for the next cycle.
  always_comb begin
    w_phase_nxt = r_phase;
    w_an_nxt    = AN_OFF;
    w_cath_nxt  = 8'hFF;
    case (r_phase)
      PH_BLANK: begin
        if (w_slot_nxt >= CW'(BLANK_CYCLES)) begin
          w_phase_nxt = PH_SHOW;
        end else begin
          w_phase_nxt = PH_BLANK;
        end
      end
      PH_SHOW: begin
        if (w_slot_nxt < CW'(BLANK_CYCLES)) begin
          w_phase_nxt = PH_BLANK;
        end else begin
          w_phase_nxt = PH_SHOW;
        end
        if (w_en_eff[r_digit_idx]) begin
          w_an_nxt   = ~(AN_ONE << r_digit_idx);
          w_cath_nxt = {hex_decode(r_act_value[4*r_digit_idx +: 4]), ~r_act_dp[r_digit_idx]};
        end else begin
          w_an_nxt   = AN_OFF;
          w_cath_nxt = 8'hFF;
        end
      end
      default: w_phase_nxt = PH_BLANK;
    endcase
  end

  // Scan timing, phase state and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_cnt   <= {CW{1'b0}};
      r_digit_idx  <= {IW{1'b0}};
      r_phase      <= PH_RESET;
      r_an         <= AN_OFF;
      r_cath       <= 8'hFF;
      r_frame_done <= 1'b0;
    end else begin
      r_slot_cnt   <= w_slot_nxt;
      r_digit_idx  <= w_idx_nxt;
      r_phase      <= w_phase_nxt;
      r_an         <= w_an_nxt;
      r_cath       <= w_cath_nxt;
      // Registered one cycle early so the pulse coincides with the wrap cycle.
      r_frame_done <= (w_slot_nxt == CW'(TICK_DIV - 1)) && (w_idx_nxt == IW'(NUM_DIGITS - 1));
    end
  end

  // Double buffer: offers park in pending and commit only at a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_value  <= {(4*NUM_DIGITS){1'b0}};
      r_act_dp     <= {NUM_DIGITS{1'b0}};
      r_act_en     <= {NUM_DIGITS{1'b0}};
      r_pend_value <= {(4*NUM_DIGITS){1'b0}};
      r_pend_dp    <= {NUM_DIGITS{1'b0}};
      r_pend_en    <= {NUM_DIGITS{1'b0}};
      r_load_ready <= 1'b1;
    end else if (w_boundary) begin
      if (w_accept) begin
        r_act_value <= bus.value;
        r_act_dp    <= bus.dp_mask;
        r_act_en    <= bus.digit_en;
      end else if (!r_load_ready) begin
        r_act_value <= r_pend_value;
        r_act_dp    <= r_pend_dp;
        r_act_en    <= r_pend_en;
      end else begin
        r_act_value <= r_act_value;
      end
      r_load_ready <= 1'b1;
    end else if (w_accept) begin
      r_pend_value <= bus.value;
      r_pend_dp    <= bus.dp_mask;
      r_pend_en    <= bus.digit_en;
      r_load_ready <= 1'b0;
    end else begin
      r_load_ready <= r_load_ready;
    end
  end

  assign bus.load_ready = r_load_ready;
  assign bus.an         = r_an;
  assign bus.cathodes   = r_cath;
  assign bus.frame_done = r_frame_done;
endmodule
